sc_schedule_ctrl: RTL
=====================

# sc_schedule_ctrl

Sequencing controller for the successive-cancellation (SC) polar decoder. It walks the SC decoding tree for a code of length N = 2^N_LOG2 and issues one f or g layer operation at a time to the LLR processing datapath. After each leaf it emits a bit-decision strobe carrying the frozen flag. It sits between the decoder top-level start/done handshake and the shared f/g processing-element array, which it owns exclusively while busy.

## Interface
- N_LOG2, 10, log2 of code length N; layers are numbered N_LOG2-1 (root) down to 0 (leaf).
- LAYER_OUT_WIDTH, 4, width of op_layer; must hold N_LOG2-1.
- INDEX_WIDTH, 10, width of bit_idx; equals N_LOG2.
- OPCNT_WIDTH, 11, width of op_cnt; must hold 2N-2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begin decoding one codeword; sampled only in IDLE.
- abort  in  1  synchronous abandon; return to IDLE next cycle, no done.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the last bit decision has been issued.
- op_valid  out  1  one-cycle pulse issuing a layer operation.
- op_type  out  1  0 = f (check-node), 1 = g (bit-node); valid with op_valid.
- op_layer  out  LAYER_OUT_WIDTH  target layer of the issued op.
- op_done  in  1  datapath finished the outstanding op; sampled only in WAIT.
- bit_valid  out  1  one-cycle pulse: leaf LLR ready, decide bit bit_idx.
- bit_idx  out  INDEX_WIDTH  current leaf index 0..N-1.
- frozen_i  in  1  frozen flag for bit_idx from an external ROM, combinational same cycle.
- bit_frozen  out  1  frozen_i registered alongside bit_valid.
- op_cnt  out  OPCNT_WIDTH  number of ops issued since start.

## Operation
- States: IDLE, ISSUE, WAIT, DECIDE, DONE.
- IDLE: on start, set bit_idx=0, op_layer=N_LOG2-1, op_type=f, op_cnt=0, and go to ISSUE.
- ISSUE: op_valid=1 for this cycle, op_cnt increments, and the state goes to WAIT.
- WAIT: hold op_type/op_layer stable. On op_done:
  - op_layer==0: go to DECIDE.
  - otherwise: op_layer -= 1, op_type=f, go to ISSUE.
- DECIDE: bit_valid=1 and bit_frozen=frozen_i for this cycle.
  - bit_idx==N-1: go to DONE.
  - otherwise: bit_idx += 1, op_layer = ctz(bit_idx+1) (trailing zeros of the new index), op_type=g, go to ISSUE.
- DONE: done=1 for one cycle, then IDLE. bit_idx holds N-1 and op_cnt holds its final value until the next start.
- Per codeword:
  - bit 0 issues N_LOG2 f ops, from layer N_LOG2-1 down to layer 0.
  - bit i>0 issues one g op at layer ctz(i), then f ops down to layer 0.
  - Total ops per codeword = 2N-2 (2046 at default).
- Boundary conditions:
  - start while busy is ignored.
  - op_done outside WAIT is ignored.
  - abort has priority over all transitions: the next state is IDLE, and done, op_valid and bit_valid are 0 from that cycle on.
  - start and abort together in IDLE: abort wins and the state stays IDLE.
  - ctz arithmetic never exceeds N_LOG2-1 for indices 1..N-1.
  - bit_idx does not wrap past N-1.

## Timing
- Reset: state=IDLE. busy, done, op_valid, op_type, bit_valid and bit_frozen are 0; op_layer=0, bit_idx=0, op_cnt=0.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- start is accepted at edge k, and op_valid is high in cycle k+1.
- Each op takes at least 2 cycles (ISSUE plus a single WAIT cycle when op_done returns immediately); each stall cycle of op_done adds 1.
- DECIDE and DONE each take 1 cycle.
- Minimum latency from start to done at default N: 1 + 2·2046 + 1024 = 5117 cycles.
- Asynchronous rst mid-operation forces the reset values immediately; no done is produced.

## Test plan
- Reset: assert rst mid-WAIT → all outputs return to reset values asynchronously; the next start decodes from bit 0.
- N_LOG2=2, op_done returned the cycle after each op_valid → op sequence (f,1)(f,0)D0 (g,0)D1 (g,1)(f,0)D2 (g,0)D3, where Dn is bit_valid with bit_idx=n. op_cnt=6 at done; done arrives 17 cycles after start.
- Default N, op_done delayed randomly 0–5 cycles → exactly 2046 op_valid pulses and 1024 bit_valid pulses with indices 0..1023 in order. op_layer for each g equals ctz(bit_idx), and done fires once.
- Frozen pass-through: frozen_i = bit_idx[0] → bit_frozen matches it on every bit_valid.
- Abort at bit 500 during WAIT → IDLE next cycle with no done. start is ignored while busy, and a new start afterwards begins at bit_idx=0 with op (f,9).
- Spurious op_done asserted in ISSUE, DECIDE or IDLE → no state advance and no extra op_valid.

Source files
------------

// File: rtl/sc_schedule_ctrl.sv
// Successive-cancellation polar decoder scheduler: walks the SC tree for N = 2^N_LOG2,
// issuing one f/g layer op at a time and a bit-decision strobe after each leaf.
module sc_schedule_ctrl #(
    parameter int unsigned N_LOG2          = 10,
    parameter int unsigned LAYER_OUT_WIDTH = 4,
    parameter int unsigned INDEX_WIDTH     = 10,
    parameter int unsigned OPCNT_WIDTH     = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       op_valid,
    output logic                       op_type,
    output logic [LAYER_OUT_WIDTH-1:0] op_layer,
    input  logic                       op_done,
    output logic                       bit_valid,
    output logic [INDEX_WIDTH-1:0]     bit_idx,
    input  logic                       frozen_i,
    output logic                       bit_frozen,
    output logic [OPCNT_WIDTH-1:0]     op_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [INDEX_WIDTH-1:0]     LAST_IDX   = INDEX_WIDTH'((1 << N_LOG2) - 1);
    localparam logic [LAYER_OUT_WIDTH-1:0] ROOT_LAYER = LAYER_OUT_WIDTH'(N_LOG2 - 1);

    logic [2:0]                 state_q, state_d;
    logic [INDEX_WIDTH-1:0]     bit_idx_q, bit_idx_d;
    logic [LAYER_OUT_WIDTH-1:0] op_layer_q, op_layer_d;
    logic                       op_type_q, op_type_d;
    logic [OPCNT_WIDTH-1:0]     op_cnt_q, op_cnt_d;
    logic                       bit_frozen_q, bit_frozen_d;
    logic [INDEX_WIDTH-1:0]     next_idx;

    // Trailing-zero count; the argument is always 1..N-1 so the result stays below N_LOG2.
    function automatic logic [LAYER_OUT_WIDTH-1:0] ctz(input logic [INDEX_WIDTH-1:0] v);
        logic [LAYER_OUT_WIDTH-1:0] n;
        logic                       found;
        n     = '0;
        found = 1'b0;
        for (int i = 0; i < int'(INDEX_WIDTH); i++) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + LAYER_OUT_WIDTH'(1);
                end
            end
        end
        return n;
    endfunction

    // Next-state logic for the tree walk; abort overrides every transition.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        op_layer_d   = op_layer_q;
        op_type_d    = op_type_q;
        op_cnt_d     = op_cnt_q;
        bit_frozen_d = 1'b0;
        next_idx     = bit_idx_q + INDEX_WIDTH'(1);
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bit_idx_d  = '0;
                        op_layer_d = ROOT_LAYER;
                        op_type_d  = 1'b0;
                        op_cnt_d   = '0;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    op_cnt_d = op_cnt_q + OPCNT_WIDTH'(1);
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (op_done) begin
                        if (op_layer_q == '0) begin
                            // bit_idx is already stable here, so frozen_i can be captured
                            // now and presented together with bit_valid in DECIDE.
                            bit_frozen_d = frozen_i;
                            state_d      = ST_DECIDE;
                        end else begin
                            op_layer_d = op_layer_q - LAYER_OUT_WIDTH'(1);
                            op_type_d  = 1'b0;
                            state_d    = ST_ISSUE;
                        end
                    end
                end
                ST_DECIDE: begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_idx_d  = next_idx;
                        op_layer_d = ctz(next_idx);
                        op_type_d  = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            op_layer_q   <= '0;
            op_type_q    <= 1'b0;
            op_cnt_q     <= '0;
            bit_frozen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            op_layer_q   <= op_layer_d;
            op_type_q    <= op_type_d;
            op_cnt_q     <= op_cnt_d;
            bit_frozen_q <= bit_frozen_d;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        op_valid   = (state_q == ST_ISSUE);
        bit_valid  = (state_q == ST_DECIDE);
        op_type    = op_type_q;
        op_layer   = op_layer_q;
        bit_idx    = bit_idx_q;
        op_cnt     = op_cnt_q;
        bit_frozen = bit_frozen_q;
    end

endmodule
